pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master: the hazard controller; slave: the pipeline stages it steers.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd_addr;
  logic        ex_mem_read;
  logic        ex_redirect;
  logic        dmem_req;
  logic        dmem_ready;
  logic        imem_ready;

  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_stall;
  logic        id_ex_flush;
  logic        ex_mem_stall;
  logic        mem_wb_flush;
  logic        mem_err;
  logic        fsm_state;
  logic [31:0] stall_cycles;
  logic [31:0] redirect_count;

  modport master (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_rd_addr, ex_mem_read, ex_redirect, dmem_req, dmem_ready, imem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_flush, mem_err, fsm_state, stall_cycles, redirect_count
  );

  modport slave (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_rd_addr, ex_mem_read, ex_redirect, dmem_req, dmem_ready, imem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_flush, mem_err, fsm_state, stall_cycles, redirect_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use, redirect, imem wait and dmem freeze with timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.master  bus
);

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_c;
  logic             freeze_c;
  logic             mem_err_c;
  logic             pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c;
  logic             id_ex_flush_c, ex_mem_stall_c, mem_wb_flush_c;

  assign lu_c = bus.ex_mem_read && (bus.ex_rd_addr != 5'd0) &&
                ((bus.id_uses_rs1 && (bus.id_rs1_addr == bus.ex_rd_addr)) ||
                 (bus.id_uses_rs2 && (bus.id_rs2_addr == bus.ex_rd_addr)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    freeze_c       = 1'b0;
    mem_err_c      = 1'b0;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    mem_wb_flush_c = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.dmem_req && !bus.dmem_ready) begin
          state_d  = MEM_WAIT;
          cnt_d    = CNT_W'(1);
          freeze_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q < TIMEOUT_C) begin
          cnt_d    = cnt_q + CNT_W'(1);
          freeze_c = 1'b1;
        end else begin
          // Give up on the access: release the pipe and flag the error.
          state_d   = RUN;
          cnt_d     = '0;
          mem_err_c = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    if (freeze_c) begin
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_stall_c = 1'b1;
      mem_wb_flush_c = 1'b1;
    end else if (bus.ex_redirect) begin
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
    end else if (lu_c) begin
      pc_stall_c    = 1'b1;
      if_id_stall_c = 1'b1;
      id_ex_flush_c = 1'b1;
    end else if (!bus.imem_ready) begin
      pc_stall_c    = 1'b1;
      if_id_flush_c = 1'b1;
    end

    // Reset silences every control immediately, even mid-freeze.
    if (rst) begin
      freeze_c       = 1'b0;
      mem_err_c      = 1'b0;
      pc_stall_c     = 1'b0;
      if_id_stall_c  = 1'b0;
      if_id_flush_c  = 1'b0;
      id_ex_stall_c  = 1'b0;
      id_ex_flush_c  = 1'b0;
      ex_mem_stall_c = 1'b0;
      mem_wb_flush_c = 1'b0;
    end
  end

  assign bus.pc_stall     = pc_stall_c;
  assign bus.if_id_stall  = if_id_stall_c;
  assign bus.if_id_flush  = if_id_flush_c;
  assign bus.id_ex_stall  = id_ex_stall_c;
  assign bus.id_ex_flush  = id_ex_flush_c;
  assign bus.ex_mem_stall = ex_mem_stall_c;
  assign bus.mem_wb_flush = mem_wb_flush_c;
  assign bus.mem_err      = mem_err_c;
  assign bus.fsm_state    = (state_q == MEM_WAIT);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, redirect_count_q;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      if (pc_stall_c && (stall_cycles_q != 32'hFFFF_FFFF))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (!freeze_c && bus.ex_redirect && (redirect_count_q != 32'hFFFF_FFFF))
        redirect_count_q <= redirect_count_q + 32'd1;
    end
  end

  assign bus.stall_cycles   = stall_cycles_q;
  assign bus.redirect_count = redirect_count_q;
`else
  assign bus.stall_cycles   = 32'h0;
  assign bus.redirect_count = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus multi-cycle freeze/timeout/reset sequences.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO = 16;

  // Output vector layout: {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
  //                        id_ex_flush, ex_mem_stall, mem_wb_flush, mem_err, fsm_state}
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110010000;
  localparam logic [8:0] RDR  = 9'b001010000;
  localparam logic [8:0] IMW  = 9'b101000000;
  localparam logic [8:0] FRZ  = 9'b110101100;
  localparam logic [8:0] ERR  = 9'b000000010;
  localparam logic [8:0] ST   = 9'b000000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus();

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] exrd;
    logic       mr;
    logic       redir;
    logic       dreq;
    logic       drdy;
    logic       irdy;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [8:0] exp;
    logic       redir;
  } sb_t;

  sb_t         sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_stall = 32'd0;
  logic [31:0] exp_redir = 32'd0;
  vec_t        tbl[13];

  function automatic vec_t mk(input string nm, input int rs1, input int rs2, input bit u1,
                              input bit u2, input int exrd, input bit mr, input bit rd,
                              input bit dq, input bit dy, input bit iy, input logic [8:0] e);
    vec_t v;
    v.name = nm;   v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2;
    v.exrd = 5'(exrd); v.mr = mr; v.redir = rd; v.dreq = dq; v.drdy = dy; v.irdy = iy;
    v.exp  = e;
    return v;
  endfunction

  task automatic check_out();
    sb_t        e;
    logic [8:0] act;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e   = sb.pop_front();
    act = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
           bus.id_ex_flush, bus.ex_mem_stall, bus.mem_wb_flush, bus.mem_err, bus.fsm_state};
    n_vec++;
    if (act !== e.exp) begin
      n_err++;
      $display("FAIL %s: outputs got %b want %b", e.name, act, e.exp);
    end
    if (rst) begin
      exp_stall = 32'd0;
      exp_redir = 32'd0;
    end
    n_vec++;
    if ((bus.stall_cycles !== exp_stall) || (bus.redirect_count !== exp_redir)) begin
      n_err++;
      $display("FAIL %s_perf: counters got %0d/%0d want %0d/%0d", e.name,
               bus.stall_cycles, bus.redirect_count, exp_stall, exp_redir);
    end
`ifdef HAZARD_PERF_CNT_EN
    if (!rst) begin
      if (e.exp[8]) exp_stall = exp_stall + 32'd1;
      if (e.redir && !e.exp[3]) exp_redir = exp_redir + 32'd1;
    end
`endif
  endtask

  // rmode: 0 rst low, 1 rst high, 2 rst raised mid-cycle after the vector settles
  task automatic step(input vec_t v, input int rmode);
    @(posedge clk);
    #1;
    if (rmode == 0) rst = 1'b0;
    else if (rmode == 1) rst = 1'b1;
    bus.id_rs1_addr = v.rs1;  bus.id_rs2_addr = v.rs2;
    bus.id_uses_rs1 = v.u1;   bus.id_uses_rs2 = v.u2;
    bus.ex_rd_addr  = v.exrd; bus.ex_mem_read = v.mr;
    bus.ex_redirect = v.redir;
    bus.dmem_req    = v.dreq; bus.dmem_ready  = v.drdy;
    bus.imem_ready  = v.irdy;
    sb.push_back('{v.name, v.exp, v.redir});
    if (rmode == 2) begin
      #1;
      n_vec++;
      if (bus.pc_stall !== 1'b1) begin
        n_err++;
        $display("FAIL pre_rst_freeze: pc_stall got %b want 1", bus.pc_stall);
      end
      #1 rst = 1'b1;
    end
    @(negedge clk);
    check_out();
  endtask

  initial begin
    vec_t v;
    bus.id_rs1_addr = '0; bus.id_rs2_addr = '0; bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.ex_rd_addr = '0; bus.ex_mem_read = 1'b0; bus.ex_redirect = 1'b0;
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b1; bus.imem_ready = 1'b1;

    tbl[0]  = mk("idle",        0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE);
    tbl[1]  = mk("lu_rs1",      5, 0, 1, 0, 5, 1, 0, 0, 1, 1, LU);
    tbl[2]  = mk("lu_clear",    5, 0, 1, 0, 7, 0, 0, 0, 1, 1, NONE);
    tbl[3]  = mk("rd_zero",     0, 0, 1, 0, 0, 1, 0, 0, 1, 1, NONE);
    tbl[4]  = mk("lu_rs2",      3, 9, 1, 1, 9, 1, 0, 0, 1, 1, LU);
    tbl[5]  = mk("unused_rs1",  5, 0, 0, 0, 5, 1, 0, 0, 1, 1, NONE);
    tbl[6]  = mk("no_load",     5, 5, 1, 1, 5, 0, 0, 0, 1, 1, NONE);
    tbl[7]  = mk("redir_lu",    5, 0, 1, 0, 5, 1, 1, 0, 1, 1, RDR);
    tbl[8]  = mk("imem_wait",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, IMW);
    tbl[9]  = mk("lu_imem",     5, 0, 1, 0, 5, 1, 0, 0, 1, 0, LU);
    tbl[10] = mk("redir_imem",  0, 0, 0, 0, 0, 0, 1, 0, 1, 0, RDR);
    tbl[11] = mk("dmem_hit",    0, 0, 0, 0, 0, 0, 0, 1, 1, 1, NONE);
    tbl[12] = mk("rs_mismatch", 4, 6, 1, 1, 5, 1, 0, 0, 1, 1, NONE);

    // Outputs forced low under reset even with every hazard input active.
    step(mk("rst_quiet_a", 5, 5, 1, 1, 5, 1, 1, 1, 0, 0, NONE), 1);
    step(mk("rst_quiet_b", 5, 5, 1, 1, 5, 1, 1, 1, 0, 0, NONE), 1);

    for (int i = 0; i < 13; i++) step(tbl[i], 0);

    // Short dmem miss, plain and with a redirect waiting in EX.
    for (int r = 0; r < 2; r++) begin
      v = mk("frz_c1", 0, 0, 0, 0, 0, 0, r[0], 1, 0, 1, FRZ);
      step(v, 0);
      v.name = "frz_c2"; v.exp = FRZ | ST; step(v, 0);
      v.name = "frz_c3"; step(v, 0);
      v.name = "frz_release"; v.drdy = 1'b1; v.exp = (r == 1) ? (RDR | ST) : ST;
      step(v, 0);
      step(mk("after_release", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE), 0);
    end

    // Timeout: TO freeze cycles, error pulse, then back in RUN.
    v = mk("to_frz", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ);
    for (int i = 1; i <= int'(TO); i++) begin
      v.exp = (i > 1) ? (FRZ | ST) : FRZ;
      step(v, 0);
    end
    v.name = "to_err"; v.exp = ERR | ST; step(v, 0);
    step(mk("to_run", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE), 0);

    // Reset during MEM_WAIT: outputs drop within the same cycle.
    v = mk("rw_frz", 5, 0, 1, 0, 5, 1, 1, 1, 0, 1, FRZ);
    for (int i = 1; i <= 4; i++) begin
      v.exp = (i > 1) ? (FRZ | ST) : FRZ;
      step(v, 0);
    end
    v.name = "rw_rst"; v.exp = NONE; step(v, 2);
    step(mk("rw_hold", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE), 1);
    step(mk("rw_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE), 0);
    step(mk("rw_lu",   5, 0, 1, 0, 5, 1, 0, 0, 1, 1, LU), 0);
    step(mk("rw_end",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
